dff_seq_ctrl: RTL and testbench
===============================

DFF_SEQ_CTRL -- requirements
Module: dff_seq_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; clock port named clk, reset port named rst.
REQ-002 Parameter: WIDTH, 8, number of pattern bits per run (legal range 2..16).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 pattern  input  WIDTH  bits to drive, captured on the accepting edge.
REQ-007 ff_d  output  1  serial drive into the external flip-flop data input.
REQ-008 ff_q  input  1  external flip-flop out.
REQ-009 ff_qn  input  1  external flip-flop nout.
REQ-010 busy  output  1  high in DRIVE, RUN, FLUSH.
REQ-011 done  output  1  one-cycle pulse in DONE.
REQ-012 pass  output  1  result of the last completed run.
REQ-013 err_count  output  4  mismatched-bit count, saturating.
REQ-014 comp_err  output  1  sticky complement-violation flag.

Function
REQ-015 States SHALL be IDLE, DRIVE, RUN, FLUSH, DONE, held in a registered state variable.
REQ-016 IDLE to DRIVE on edge E0 with start=1: capture pattern, clear err_count and comp_err, set bit index to 0.
REQ-017 DRIVE: ff_d = pattern[0]; no compare; next edge moves to RUN with index 1.
REQ-018 RUN with index k: ff_d = pattern[k]; at the closing edge, compare ff_q with pattern[k-1]; increment index.
REQ-019 RUN SHALL last WIDTH-1 cycles; after index WIDTH-1, the next edge moves to FLUSH.
REQ-020 FLUSH: ff_d = 0; at the closing edge, compare ff_q with pattern[WIDTH-1]; move to DONE.
REQ-021 Compares SHALL occur at edges E2 through E(WIDTH+1), exactly WIDTH compares, bits LSB first.
REQ-022 DONE: done=1 for one cycle; pass = (err_count==0); next edge returns to IDLE unconditionally.
REQ-023 busy SHALL be high for exactly WIDTH+1 cycles per run.
REQ-024 A mismatch SHALL increment err_count by 1; err_count SHALL saturate at 15 and never wrap.
REQ-025 start in any state other than IDLE, including DONE, SHALL be ignored and not queued.
REQ-026 pattern changes after E0 SHALL NOT affect the run in progress.
REQ-027 pass, err_count and comp_err SHALL hold their values from DONE until the next accepted start.
REQ-028 ff_d SHALL be 0 in IDLE, FLUSH and DONE.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE, overriding start and any state, including a run in progress.
REQ-030 Reset values: ff_d=0, busy=0, done=0, pass=0, err_count=0, comp_err=0, bit index 0.

Configuration
REQ-031 Macro NOUT_CHECK_EN, when defined: at each compare edge, ff_qn != ~ff_q SHALL set comp_err and count one error for that bit; one error maximum per bit even if ff_q also mismatches.
REQ-032 Without NOUT_CHECK_EN: ff_qn is ignored, comp_err is tied to 0, and the port list is unchanged.

Verification (ideal flip-flop model: ff_q <= ff_d each edge, ff_qn = ~ff_q)
REQ-033 rst held 2 cycles then start=1, pattern=8'hA5 -> busy high 9 cycles; ff_d sequence 1,0,1,0,0,1,0,1; done pulse; pass=1; err_count=0.
REQ-034 Flip-flop model inverts bit 3 for the 8'hA5 run -> err_count=1, pass=0 at done.
REQ-035 Model output stuck at 0 with pattern=8'hFF -> err_count=8; repeat with WIDTH=16, pattern=16'hFFFF -> err_count saturates at 15.
REQ-036 start pulsed during RUN and during DONE -> ignored, no second run; rst asserted during RUN at index 4 -> IDLE next cycle, all outputs at reset values, no done pulse.
REQ-037 With NOUT_CHECK_EN, ff_qn forced equal to ff_q on one compare -> comp_err=1, err_count=1, pass=0; without the macro, the same stimulus gives comp_err=0 and pass=1.

Source files
------------

// File: rtl/dff_seq_ctrl.sv
// dff_seq_ctrl: drives a WIDTH-bit pattern serially into an external
// flip-flop (LSB first) and checks its output one cycle later.
// Optional feature: define NOUT_CHECK_EN to also check that ff_qn is the
// complement of ff_q at every compare edge (sets comp_err, counts an error).
//
// state | meaning
// IDLE  | waiting for start; ff_d = 0
// DRIVE | first bit on ff_d, nothing to compare yet
// RUN   | bit idx on ff_d, previous bit compared at the closing edge
// FLUSH | ff_d = 0, last bit compared at the closing edge
// DONE  | one-cycle done pulse, pass valid
module dff_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             ff_d,
  input  logic             ff_q,
  input  logic             ff_qn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic             comp_err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, DRIVE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] drv_sh;   // bits still to be driven, next one in bit 0
  logic [WIDTH-1:0] chk_sh;   // bits still to be checked, next one in bit 0
  logic             cmp_en;
  logic             q_bad;
  logic             qn_bad;
  logic             bit_err;
  logic [3:0]       err_next;

  // Compare the flip-flop output against the bit driven one cycle earlier
  always_comb begin
    cmp_en = (state == RUN) || (state == FLUSH);
    q_bad  = (ff_q != chk_sh[0]);
`ifdef NOUT_CHECK_EN
    qn_bad = (ff_qn == ff_q);
`else
    qn_bad = 1'b0;
`endif
    // A bit counts at most once even if both outputs are wrong
    bit_err  = cmp_en && (q_bad || qn_bad);
    err_next = (bit_err && (err_count != 4'hF)) ? err_count + 4'd1 : err_count;
  end

  // Sequencer: state, serial drive, error counting and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drv_sh    <= '0;
      chk_sh    <= '0;
      ff_d      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 4'd0;
    end else begin
      done      <= 1'b0;
      err_count <= err_next;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            drv_sh    <= pattern >> 1;
            chk_sh    <= pattern;
            ff_d      <= pattern[0];
            idx       <= '0;
            busy      <= 1'b1;
            err_count <= 4'd0;
          end
        end
        DRIVE: begin
          state  <= RUN;
          idx    <= IW'(1);
          ff_d   <= drv_sh[0];
          drv_sh <= drv_sh >> 1;
        end
        RUN: begin
          chk_sh <= chk_sh >> 1;
          if (idx == LAST) begin
            state <= FLUSH;
            ff_d  <= 1'b0;
          end else begin
            idx    <= idx + IW'(1);
            ff_d   <= drv_sh[0];
            drv_sh <= drv_sh >> 1;
          end
        end
        FLUSH: begin
          state <= DONE;
          ff_d  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == 4'd0);
          idx   <= '0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NOUT_CHECK_EN
  // Sticky complement-violation flag, cleared when a new run is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      comp_err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      comp_err <= 1'b0;
    end else if (cmp_en && qn_bad) begin
      comp_err <= 1'b1;
    end
  end
`else
  logic unused_qn;
  assign unused_qn = ff_qn;
  assign comp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dff_seq_ctrl.sv
// Bench for dff_seq_ctrl: two instances (WIDTH 8 and 16) each driving an
// ideal flip-flop model with injectable faults; expectations come from a
// per-bit model of the run.
module tb_dff_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  pat8 = '0;
  logic [15:0] pat16 = '0;
  logic        ff_d8, ff_q8, ff_qn8, busy8, done8, pass8, comp8;
  logic        ff_d16, ff_q16, ff_qn16, busy16, done16, pass16, comp16;
  logic [3:0]  err8, err16;

  logic q8_r = 1'b0, q16_r = 1'b0;
  logic flip_now = 1'b0, qn_bad = 1'b0, stuck = 1'b0;

  int errors = 0;
  int checks = 0;

`ifdef NOUT_CHECK_EN
  localparam bit NOUT = 1'b1;
`else
  localparam bit NOUT = 1'b0;
`endif

  dff_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .pattern(pat8),
    .ff_d(ff_d8), .ff_q(ff_q8), .ff_qn(ff_qn8),
    .busy(busy8), .done(done8), .pass(pass8),
    .err_count(err8), .comp_err(comp8)
  );

  dff_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .pattern(pat16),
    .ff_d(ff_d16), .ff_q(ff_q16), .ff_qn(ff_qn16),
    .busy(busy16), .done(done16), .pass(pass16),
    .err_count(err16), .comp_err(comp16)
  );

  // External flip-flop models with fault injection
  always @(posedge clk) begin
    q8_r  <= ff_d8;
    q16_r <= ff_d16;
  end
  assign ff_q8   = stuck ? 1'b0 : (q8_r ^ flip_now);
  assign ff_qn8  = qn_bad ? ff_q8 : ~ff_q8;
  assign ff_q16  = stuck ? 1'b0 : (q16_r ^ flip_now);
  assign ff_qn16 = qn_bad ? ff_q16 : ~ff_q16;

  // Expected error count: one per faulty bit, saturating at 15
  function automatic int exp_errs(input int w, input logic [15:0] pat,
                                  input logic [15:0] flip, input bit stk,
                                  input logic [15:0] qnm);
    int n;
    logic q;
    n = 0;
    for (int j = 0; j < w; j++) begin
      q = stk ? 1'b0 : (pat[j] ^ flip[j]);
      if ((q != pat[j]) || (NOUT && qnm[j])) n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  task automatic do_run(input int sel, input logic [15:0] pat,
                        input logic [15:0] flip, input bit stk,
                        input logic [15:0] qnm, input bit poke,
                        input string name);
    int w, ee, busy_n, done_n, done_at, d_bad;
    bit ep, ec;
    logic b, dn, d, p, ce;
    logic [3:0] e;
    w  = sel ? 16 : 8;
    ee = exp_errs(w, pat, flip, stk, qnm);
    ep = (ee == 0);
    ec = NOUT && (qnm != 16'h0);
    busy_n = 0; done_n = 0; done_at = -1; d_bad = 0;
    @(negedge clk);
    stuck = stk;
    if (sel != 0) begin pat16 = pat; start16 = 1'b1; end
    else begin pat8 = pat[7:0]; start8 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    for (int c = 0; c < w + 8; c++) begin
      flip_now = (c >= 1 && c <= w) ? flip[c-1] : 1'b0;
      qn_bad   = (c >= 1 && c <= w) ? qnm[c-1] : 1'b0;
      pat8  = 8'($urandom);
      pat16 = 16'($urandom);
      if (poke && (c == 2 || c == w + 1)) begin
        if (sel != 0) start16 = 1'b1; else start8 = 1'b1;
      end else begin
        start8 = 1'b0; start16 = 1'b0;
      end
      @(negedge clk);
      b  = sel ? busy16 : busy8;
      dn = sel ? done16 : done8;
      d  = sel ? ff_d16 : ff_d8;
      p  = sel ? pass16 : pass8;
      e  = sel ? err16  : err8;
      ce = sel ? comp16 : comp8;
      if (b) begin
        busy_n++;
        if (d !== ((c < w) ? pat[c] : 1'b0)) d_bad++;
      end else if (d !== 1'b0) d_bad++;
      if (dn) begin
        done_n++;
        done_at = c;
        checks++;
        if (e !== 4'(ee)) begin errors++; $display("FAIL %s err_count at done: got %0d want %0d", name, e, ee); end
        checks++;
        if (p !== ep) begin errors++; $display("FAIL %s pass at done: got %b want %b", name, p, ep); end
        checks++;
        if (ce !== ec) begin errors++; $display("FAIL %s comp_err at done: got %b want %b", name, ce, ec); end
      end
      @(posedge clk); #1;
    end
    flip_now = 1'b0; qn_bad = 1'b0; stuck = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    checks++;
    if (busy_n != w + 1) begin errors++; $display("FAIL %s busy cycles: got %0d want %0d", name, busy_n, w + 1); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL %s done pulses: got %0d want 1", name, done_n); end
    checks++;
    if (done_at != w + 1) begin errors++; $display("FAIL %s done cycle: got %0d want %0d", name, done_at, w + 1); end
    checks++;
    if (d_bad != 0) begin errors++; $display("FAIL %s ff_d sequence: got %0d bad cycles want 0", name, d_bad); end
    e = sel ? err16 : err8;
    p = sel ? pass16 : pass8;
    checks++;
    if (e !== 4'(ee) || p !== ep) begin
      errors++; $display("FAIL %s hold after done: got err=%0d pass=%b want err=%0d pass=%b", name, e, p, ee, ep);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; start16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ff_d8, busy8, done8, pass8, err8, comp8} !== 9'b0) begin
      errors++; $display("FAIL reset w8: got %b want 0", {ff_d8, busy8, done8, pass8, err8, comp8});
    end
    checks++;
    if ({ff_d16, busy16, done16, pass16, err16, comp16} !== 9'b0) begin
      errors++; $display("FAIL reset w16: got %b want 0", {ff_d16, busy16, done16, pass16, err16, comp16});
    end
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset start override: got busy=%b want 0", busy8); end
  endtask

  task automatic test_abort();
    int busy_n, done_n;
    busy_n = 0; done_n = 0;
    do_run(0, 16'h00A5, 16'h0, 1'b0, 16'h0, 1'b0, "abort_prep");
    @(negedge clk);
    pat8 = 8'h3C; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      rst = (c == 4);
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) done_n++;
      if (c == 5) begin
        checks++;
        if ({ff_d8, busy8, done8, pass8, err8, comp8} !== 9'b0) begin
          errors++; $display("FAIL abort reset values: got %b want 0", {ff_d8, busy8, done8, pass8, err8, comp8});
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    checks++;
    if (busy_n != 5) begin errors++; $display("FAIL abort busy cycles: got %0d want 5", busy_n); end
    checks++;
    if (done_n != 0) begin errors++; $display("FAIL abort done pulses: got %0d want 0", done_n); end
  endtask

  task automatic test_random();
    logic [15:0] pat, flip, qnm;
    int sel;
    for (int i = 0; i < 8; i++) begin
      sel  = int'($urandom_range(0, 1));
      pat  = 16'($urandom);
      flip = 16'($urandom & $urandom & $urandom);
      qnm  = (i % 3 == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
      if (sel == 0) begin flip[15:8] = '0; qnm[15:8] = '0; end
      do_run(sel, pat, flip, 1'b0, qnm, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    do_run(0, 16'h00A5, 16'h0000, 1'b0, 16'h0, 1'b0, "basic_a5");
    do_run(0, 16'h00A5, 16'h0008, 1'b0, 16'h0, 1'b0, "flip_bit3");
    do_run(0, 16'h00FF, 16'h0000, 1'b1, 16'h0, 1'b0, "stuck_w8");
    do_run(1, 16'hFFFF, 16'h0000, 1'b1, 16'h0, 1'b0, "stuck_w16_sat");
    do_run(0, 16'h005A, 16'h0000, 1'b0, 16'h0, 1'b1, "start_ignored");
    do_run(0, 16'h00A5, 16'h0000, 1'b0, 16'h0004, 1'b0, "nout_check");
    do_run(1, 16'h8001, 16'hC003, 1'b0, 16'h0001, 1'b0, "w16_edges");
    test_abort();
    test_random();
    do_run(0, 16'h0081, 16'h0081, 1'b0, 16'h0, 1'b0, "back_to_back_a");
    do_run(0, 16'h007E, 16'h0000, 1'b0, 16'h0, 1'b0, "back_to_back_b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
